// File: rtl/target_sequencer.sv
// target_sequencer: runs one shooting round (random target pick, LED drive, LDR debounce,
// timeout, hit/miss scoring). Define SPEEDUP_EN to shrink the per-target time limit after each hit.
module target_sequencer #(
  parameter int         N_TARGETS = 7,
  parameter int         ROUND_LEN = 11,
  parameter int         TIMEOUT   = 15000,
  parameter int         DEBOUNCE  = 4,
  parameter int         HOME_IDX  = 3,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic [N_TARGETS-1:0] ldr_sensors,
  output logic [N_TARGETS-1:0] leds_r,
  output logic [2:0]           target_idx,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [3:0]           score,
  output logic                 busy,
  output logic                 round_done
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE + 1);

  localparam logic [TMO_W-1:0]     TMO_ONE   = TMO_W'(1);
  localparam logic [DEB_W-1:0]     DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0]     DEB_HIT   = DEB_W'(DEBOUNCE - 1);
  localparam logic [N_TARGETS-1:0] HOME_LEDS = N_TARGETS'(1) << HOME_IDX;
  localparam logic [2:0]           HOME_I    = 3'(HOME_IDX);
  localparam logic [3:0]           REM_INIT  = 4'(ROUND_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SHOW,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t           state;
  logic [7:0]       lfsr;
  logic [2:0]       prev;
  logic [TMO_W-1:0] tmo;
  logic [DEB_W-1:0] deb;
  logic [3:0]       remaining;

  logic [TMO_W-1:0] tmo_last;
  logic [2:0]       cand_mod;
  logic [2:0]       prev_next;
  logic [2:0]       cand;
  logic             tgt_low;
  logic             rel_high;
  logic             show_hit;
  logic             show_miss;

`ifdef SPEEDUP_EN
  localparam int LIM_W = $clog2(TIMEOUT + 1);
  localparam logic [LIM_W-1:0] LIM_INIT  = LIM_W'(TIMEOUT);
  localparam logic [LIM_W-1:0] LIM_STEP  = LIM_W'(TIMEOUT / 16);
  localparam logic [LIM_W-1:0] LIM_FLOOR = LIM_W'(TIMEOUT / 4);
  localparam logic [LIM_W-1:0] LIM_ONE   = LIM_W'(1);

  logic [LIM_W-1:0] lim;
  logic [LIM_W-1:0] lim_after_hit;

  // Each hit shortens the limit for later targets, never below a quarter of TIMEOUT.
  always_comb begin
    lim_after_hit = (lim < LIM_FLOOR + LIM_STEP) ? LIM_FLOOR : lim - LIM_STEP;
    tmo_last      = TMO_W'(lim - LIM_ONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lim <= LIM_INIT;
    end else if (state == S_IDLE && start) begin
      lim <= LIM_INIT;
    end else if (show_hit) begin
      lim <= lim_after_hit;
    end
  end
`else
  always_comb begin
    tmo_last = TMO_W'(TIMEOUT - 1);
  end
`endif

  // Modulo equals the single subtract for N_TARGETS>=4 and stays in range for smaller counts.
  always_comb begin
    cand_mod  = 3'(int'(lfsr[2:0]) % N_TARGETS);
    prev_next = (int'(prev) + 1 >= N_TARGETS) ? 3'd0 : prev + 3'd1;
    cand      = (cand_mod == prev) ? prev_next : cand_mod;
    tgt_low   = ~ldr_sensors[target_idx];
    rel_high  = ldr_sensors[prev];
    show_hit  = (state == S_SHOW) && tick && tgt_low && (deb == DEB_HIT);
    show_miss = (state == S_SHOW) && tick && !show_hit && (tmo == tmo_last);
  end

  // Free-running so the pick depends on when the player starts and releases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      leds_r     <= HOME_LEDS;
      target_idx <= HOME_I;
      prev       <= HOME_I;
      score      <= '0;
      busy       <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      round_done <= 1'b0;
      tmo        <= '0;
      deb        <= '0;
      remaining  <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      round_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            score     <= '0;
            remaining <= REM_INIT;
            busy      <= 1'b1;
            state     <= S_ARM;
          end
        end
        S_ARM: begin
          target_idx <= cand;
          prev       <= cand;
          leds_r     <= N_TARGETS'(1) << cand;
          tmo        <= '0;
          deb        <= '0;
          state      <= S_SHOW;
        end
        S_SHOW: begin
          if (show_hit || show_miss) begin
            hit_pulse  <= show_hit;
            miss_pulse <= show_miss;
            if (show_hit && score != 4'hF) begin
              score <= score + 4'd1;
            end
            remaining <= remaining - 4'd1;
            leds_r    <= '0;
            deb       <= '0;
            state     <= S_RELEASE;
          end else if (tick) begin
            deb <= tgt_low ? deb + DEB_ONE : '0;
            if (tmo != tmo_last) begin
              tmo <= tmo + TMO_ONE;
            end
          end
        end
        // A beam still held on the old target must clear before the next one is armed.
        S_RELEASE: begin
          if (tick) begin
            if (!rel_high) begin
              deb <= '0;
            end else if (deb == DEB_HIT) begin
              deb <= '0;
              if (remaining == 4'd0) begin
                leds_r     <= '1;
                round_done <= 1'b1;
                busy       <= 1'b0;
                state      <= S_DONE;
              end else begin
                state <= S_ARM;
              end
            end else begin
              deb <= deb + DEB_ONE;
            end
          end
        end
        S_DONE: begin
          leds_r     <= HOME_LEDS;
          target_idx <= HOME_I;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  hit_miss_excl: assert property (@(posedge clk) disable iff (!rst) !(hit_pulse && miss_pulse));
  idx_in_range:  assert property (@(posedge clk) disable iff (!rst) int'(target_idx) < N_TARGETS);
  done_not_busy: assert property (@(posedge clk) disable iff (!rst) round_done |-> !busy);
  show_onehot:   assert property (@(posedge clk) disable iff (!rst) (state == S_SHOW) |-> $onehot(leds_r));

endmodule
